cdb_arbiter: RTL
================

// Module: cdb_arbiter
// PURPOSE
//  Fairness-aware arbiter for CDB write-back slots; replaces fixed-priority psel_gen selection in cdb.
//  Each cycle, grants up to GRANTS of NUM_REQ FU result registers (ALU, then MULT, then LOAD bit order).
//  Rotating round-robin priority plus per-requester age counters; starved requesters win first.
//  Outputs feed the cdb one-hot muxes (gnt_bus) and the FU avail logic (gnt).
// PARAMETERS
//  NUM_REQ       `NUM_FU_ALU+`NUM_FU_MULT+`NUM_FU_LOAD   number of requesters
//  GRANTS        `N                                      CDB slots per cycle
//  AGE_WIDTH     4                                       width of per-requester wait counter
//  STARVE_LIMIT  8                                       wait cycles before forced priority (< 2**AGE_WIDTH)
// PORTS
//  clock          in   1                  system clock
//  reset          in   1                  synchronous, active-high
//  req            in   NUM_REQ            result ready and requesting a CDB slot
//  squash         in   1                  pipeline flush: clear arbitration history
//  gnt            out  NUM_REQ            OR of all gnt_bus rows
//  gnt_bus        out  GRANTS x NUM_REQ   row k one-hot: k-th granted requester, all-zero if unused
//  starve_active  out  1                  some requester's age == STARVE_LIMIT this cycle
//  empty          out  1                  req == 0
// BEHAVIOUR
//  - Grant is combinational (0-cycle) from req plus registered rr_ptr/age[]; state updates on posedge.
//  - Reset: rr_ptr=0, age[*]=0. While reset high: gnt=0, gnt_bus=0, starve_active=0; empty tracks req.
//  - Priority order: (1) starved (age==STARVE_LIMIT && req), ascending index;
//    (2) remaining req, circular order starting at rr_ptr. Slots filled k=0..GRANTS-1 in this order.
//  - gnt_bus rows disjoint; popcount(gnt)=min(popcount(req),GRANTS); never grant a non-requester.
//  - rr_ptr update: if any round-robin (class 2) grant, rr_ptr <= (last class-2 granted index+1) mod NUM_REQ;
//    otherwise hold. Starved grants do not move rr_ptr.
//  - age[i] next: 0 if gnt[i] or !req[i]; else min(age[i]+1, STARVE_LIMIT) (saturates, never wraps).
//  - squash: gnt/gnt_bus still computed normally this cycle (results of committed-older ops drain);
//    next state rr_ptr=0, age[*]=0. squash and reset together: reset wins (identical result).
//  - More starved than GRANTS: lowest indices granted; the rest keep age saturated, win next cycle.
//  - NUM_REQ <= GRANTS: all requesters granted every cycle; ages stay 0.
//  - req dropping without grant clears age (requester withdrew; no stale priority).
// CONFIGURATION
//  CDB_ARB_STATS_EN defined: extra outputs grant_count[31:0] (sum of grants, wrapping) and
//    stall_count[31:0] (cycles with popcount(req)>GRANTS, wrapping); both 0 on reset, NOT cleared by squash.
//  Undefined: ports and counters absent; arbitration behaviour identical.
// TESTING  (NUM_REQ=5, GRANTS=2, STARVE_LIMIT=3 unless noted)
//  1 Reset, req=5'b11111 during reset -> gnt=0; first cycle after -> gnt=5'b00011, gnt_bus[0]=00001, [1]=00010.
//  2 req=11111 held 3 cycles -> gnt 00011, 01100, 10001 (rr_ptr 0->2->4->1).
//  3 req=00011 constantly, then req[4] also from cycle 0, rr_ptr held at 0 by reset
//    -> req[4] granted no later than when age[4]==3, starve_active=1 that cycle.
//  4 req=10101 with age[4]=3, age[2]=3 -> gnt_bus[0]=00100, gnt_bus[1]=10000; rr_ptr unchanged.
//  5 squash with rr_ptr=3, age[1]=2 -> same-cycle grants normal; next cycle rr_ptr=0, age[*]=0.
//  6 CDB_ARB_STATS_EN: 10 cycles req=11111 -> grant_count=20, stall_count=10; squash leaves both.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: fairness-aware arbiter for CDB write-back slots.
// Grants up to GRANTS of NUM_REQ functional-unit result registers per cycle.
// Starved requesters (age == STARVE_LIMIT) win first in ascending index order.
// The remaining slots are filled in round-robin order starting at rr_ptr.
// Latency: grant is combinational from i_req and registered rr_ptr/age; state updates on posedge.
// Optional feature: define CDB_ARB_STATS_EN to add o_grant_count/o_stall_count statistics outputs.
// Ports:
//   i_clock, i_reset        clock, synchronous active-high reset
//   i_req[NUM_REQ]          result ready, requesting a CDB slot
//   i_squash                pipeline flush: clears rr_ptr and ages for the next cycle
//   o_gnt[NUM_REQ]          OR of all o_gnt_bus rows (feeds FU avail logic)
//   o_gnt_bus[GRANTS]       row k one-hot: k-th granted requester, zero if unused (feeds CDB muxes)
//   o_starve_active         some requester's age equals STARVE_LIMIT this cycle
//   o_empty                 no requester is active
module cdb_arbiter #(
  parameter int NUM_REQ      = 5,
  parameter int GRANTS       = 2,
  parameter int AGE_WIDTH    = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                            i_clock,
  input  logic                            i_reset,
  input  logic [NUM_REQ-1:0]              i_req,
  input  logic                            i_squash,
  output logic [NUM_REQ-1:0]              o_gnt,
  output logic [GRANTS-1:0][NUM_REQ-1:0]  o_gnt_bus,
  output logic                            o_starve_active,
  output logic                            o_empty
`ifdef CDB_ARB_STATS_EN
  ,
  output logic [31:0]                     o_grant_count,
  output logic [31:0]                     o_stall_count
`endif
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW = PW + 1;
  localparam int CW = $clog2(GRANTS + 1);
  localparam logic [AGE_WIDTH-1:0] LIM = AGE_WIDTH'(STARVE_LIMIT);

  logic [PW-1:0]        r_rr_ptr;
  logic [AGE_WIDTH-1:0] r_age [NUM_REQ];

  logic [NUM_REQ-1:0]             w_sat;
  logic [NUM_REQ-1:0]             w_starved;
  logic [GRANTS-1:0][NUM_REQ-1:0] w_bus;
  logic [NUM_REQ-1:0]             w_gnt;
  logic                           w_rr_any;
  logic [PW-1:0]                  w_rr_last;
  logic [PW-1:0]                  w_rr_next;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sat[i]     = (r_age[i] == LIM);
      w_starved[i] = w_sat[i] && i_req[i];
    end
  end

  // Slot filling: starved requesters first (ascending), then round-robin from rr_ptr.
  // cnt is the next free slot; once it reaches GRANTS no further grants are made.
  always_comb begin
    logic [CW-1:0] cnt;
    logic [SW-1:0] pos;
    w_bus     = '0;
    w_rr_any  = 1'b0;
    w_rr_last = '0;
    cnt       = '0;
    pos       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_starved[i] && (cnt < CW'(GRANTS))) begin
        for (int k = 0; k < GRANTS; k++) begin
          if (cnt == CW'(k)) w_bus[k][i] = 1'b1;
        end
        cnt = cnt + 1'b1;
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      pos = SW'(r_rr_ptr) + SW'(j);
      if (pos >= SW'(NUM_REQ)) pos = pos - SW'(NUM_REQ);
      for (int i = 0; i < NUM_REQ; i++) begin
        if ((pos == SW'(i)) && i_req[i] && !w_starved[i] && (cnt < CW'(GRANTS))) begin
          for (int k = 0; k < GRANTS; k++) begin
            if (cnt == CW'(k)) w_bus[k][i] = 1'b1;
          end
          cnt       = cnt + 1'b1;
          w_rr_any  = 1'b1;
          w_rr_last = PW'(i);
        end
      end
    end
  end

  always_comb begin
    w_gnt = '0;
    for (int k = 0; k < GRANTS; k++) w_gnt = w_gnt | w_bus[k];
  end

  // Pointer moves one past the last round-robin winner; starved grants leave it alone.
  assign w_rr_next = (w_rr_last == PW'(NUM_REQ - 1)) ? '0 : (w_rr_last + 1'b1);

  // Reset masks grants; squash does not, so older committed results still drain.
  assign o_gnt_bus       = i_reset ? '0 : w_bus;
  assign o_gnt           = i_reset ? '0 : w_gnt;
  assign o_starve_active = !i_reset && (|w_sat);
  assign o_empty         = ~|i_req;

  always_ff @(posedge i_clock) begin
    if (i_reset || i_squash) begin
      r_rr_ptr <= '0;
      for (int i = 0; i < NUM_REQ; i++) r_age[i] <= '0;
    end else begin
      if (w_rr_any) r_rr_ptr <= w_rr_next;
      for (int i = 0; i < NUM_REQ; i++) begin
        // A withdrawn request forfeits its accumulated priority.
        if (w_gnt[i] || !i_req[i]) r_age[i] <= '0;
        else if (!w_sat[i])        r_age[i] <= r_age[i] + 1'b1;
      end
    end
  end

`ifdef CDB_ARB_STATS_EN
  logic [31:0] r_grant_count;
  logic [31:0] r_stall_count;
  logic [31:0] w_gnt_pop;
  logic [31:0] w_req_pop;

  always_comb begin
    w_gnt_pop = '0;
    w_req_pop = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_gnt_pop = w_gnt_pop + 32'(o_gnt[i]);
      w_req_pop = w_req_pop + 32'(i_req[i]);
    end
  end

  // Statistics survive squash; only reset clears them. Both counters wrap.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_grant_count <= '0;
      r_stall_count <= '0;
    end else begin
      r_grant_count <= r_grant_count + w_gnt_pop;
      if (w_req_pop > 32'(GRANTS)) r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign o_grant_count = r_grant_count;
  assign o_stall_count = r_stall_count;
`endif

endmodule
